// File: rtl/hamming_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hamming_pkg
//  Description : Shared Hamming SECDED helpers. Code length, data width,
//                data-index to code-position map and syndrome computation.
//                Codewords are indexed [N:1]; position i is Hamming position
//                i and bit N carries the overall even parity.
//  Revision    : 1.0  initial release
// ============================================================================
package hamming_pkg;

    // Upper bound on the number of check bits any user of this package needs.
    localparam int MAX_R = 8;
    localparam int MAX_N = 1 << MAX_R;

    // Total code length including the overall parity bit.
    function automatic int hamming_n(input int r);
        return 1 << r;
    endfunction

    // Number of data bits carried by one codeword.
    function automatic int hamming_k(input int r);
        return (1 << r) - r - 1;
    endfunction

    // Code position of data bit j. Data occupies the non-power-of-two
    // positions 3,5,6,7,9,... in ascending order.
    function automatic int data_pos(input int r, input int j);
        int cnt = 0;
        int res = 0;
        for (int p = 3; p < (1 << r); p++) begin
            if ((p & (p - 1)) != 0) begin
                if (cnt == j) res = p;
                cnt++;
            end
        end
        return res;
    endfunction

    // Syndrome: XOR of the positions (1..2**r-1) whose bit is set.
    // Bit 2**r (overall parity) is not part of the syndrome.
    function automatic int syndrome_of(input int r, input logic [MAX_N:1] code);
        int s = 0;
        for (int i = 1; i < (1 << r); i++) begin
            if (code[i]) s = s ^ i;
        end
        return s;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hamming_syndrome.sv
`default_nettype none
// ============================================================================
//  Module      : hamming_syndrome
//  Description : Combinational syndrome and overall-parity generator.
//  Ports       : code [N:1] in  - codeword, bit N = overall parity
//                syn  [R-1:0] out - Hamming syndrome over positions 1..N-1
//                par  out       - even parity over the full codeword
//  Revision    : 1.0  initial release
// ============================================================================
module hamming_syndrome
    import hamming_pkg::*;
#(
    parameter int R = 4
) (
    input  logic [hamming_n(R):1] code,
    output logic [R-1:0]          syn,
    output logic                  par
);

    localparam int N = hamming_n(R);

    // Zero-extend to the package's maximum width so one function serves
    // every configuration.
    logic [MAX_N:1] w_code_ext;

    always_comb begin
        w_code_ext        = '0;
        w_code_ext[N:1]   = code;
    end

    assign syn = R'(syndrome_of(R, w_code_ext));
    assign par = ^code;

endmodule
`default_nettype wire

// File: rtl/hamming_secded_stream_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : hamming_secded_stream_decoder
//  Description : Streaming SECDED Hamming decoder, two pipeline stages with
//                full valid/ready backpressure. S1 registers syndrome, overall
//                parity and raw code; S2 registers corrected data and flags.
//  Ports       : clk, rst (sync, active-high)
//                in_valid/in_ready/in_code[N:1]      - codeword input
//                out_valid/out_ready/out_data[K-1:0] - decoded output
//                out_error, out_uncorr, out_err_index[R-1:0] - status
//                cnt_clear, cnt_corrected, cnt_uncorr - error statistics
//  Config      : define HAMMING_DEC_STATS_EN to build the saturating error
//                counters; otherwise cnt_* are tied to zero.
//  Revision    : 1.0  initial release
// ============================================================================
module hamming_secded_stream_decoder
    import hamming_pkg::*;
#(
    parameter int R     = 4,
    parameter int CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [hamming_n(R):1] in_code,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [hamming_k(R)-1:0] out_data,
    output logic                  out_error,
    output logic                  out_uncorr,
    output logic [R-1:0]          out_err_index,
    input  logic                  cnt_clear,
    output logic [CNT_W-1:0]      cnt_corrected,
    output logic [CNT_W-1:0]      cnt_uncorr
);

    localparam int N = hamming_n(R);
    localparam int K = hamming_k(R);

    // ---------------- ready chain ----------------
    logic w_s2_free;
    logic w_s1_free;

    // ---------------- stage 1 ----------------
    logic          r_s1_valid;
    logic [R-1:0]  r_s1_syn;
    logic          r_s1_par;
    logic [N:1]    r_s1_code;
    logic [R-1:0]  w_syn;
    logic          w_par;

    // ---------------- stage 2 ----------------
    logic          r_out_valid;
    logic [K-1:0]  r_out_data;
    logic          r_out_error;
    logic          r_out_uncorr;
    logic [R-1:0]  r_out_index;

    logic          w_syn_nz;
    logic          w_flip;
    logic          w_uncorr;
    logic          w_error;
    logic [K-1:0]  w_data;
    logic [R:0]    w_unused_pbits;

    assign w_s2_free = !r_out_valid || out_ready;
    assign w_s1_free = !r_s1_valid  || w_s2_free;
    assign in_ready  = w_s1_free;

    hamming_syndrome #(
        .R    (R)
    ) u_syndrome (
        .code (in_code),
        .syn  (w_syn),
        .par  (w_par)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
        end else if (w_s1_free) begin
            r_s1_valid <= in_valid;
        end
    end

    // Payload needs no reset: it is qualified by r_s1_valid.
    always_ff @(posedge clk) begin
        if (w_s1_free && in_valid) begin
            r_s1_syn  <= w_syn;
            r_s1_par  <= w_par;
            r_s1_code <= in_code;
        end
    end

    // Decode classification. The reported index equals the syndrome in every
    // case: zero for clean and bit-N errors, s for single and double errors.
    assign w_syn_nz = |r_s1_syn;
    assign w_flip   = w_syn_nz &&  r_s1_par;
    assign w_uncorr = w_syn_nz && !r_s1_par;
    assign w_error  = w_syn_nz ||  r_s1_par;

    // Extract data bits, flipping the one at the syndrome position when a
    // single error was found.
    for (genvar j = 0; j < K; j++) begin : g_data
        localparam int P = data_pos(R, j);
        assign w_data[j] = r_s1_code[P] ^ (w_flip && (r_s1_syn == R'(P)));
    end

    // Check-bit positions and bit N are consumed only through the syndrome.
    for (genvar i = 0; i < R; i++) begin : g_pbits
        assign w_unused_pbits[i] = r_s1_code[1 << i];
    end
    assign w_unused_pbits[R] = r_s1_code[N];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_out_error  <= 1'b0;
            r_out_uncorr <= 1'b0;
            r_out_index  <= '0;
        end else if (w_s2_free) begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_out_data   <= w_data;
                r_out_error  <= w_error;
                r_out_uncorr <= w_uncorr;
                r_out_index  <= r_s1_syn;
            end
        end
    end

    assign out_valid     = r_out_valid;
    assign out_data      = r_out_data;
    assign out_error     = r_out_error;
    assign out_uncorr    = r_out_uncorr;
    assign out_err_index = r_out_index;

`ifdef HAMMING_DEC_STATS_EN
    logic [CNT_W-1:0] r_cnt_corr;
    logic [CNT_W-1:0] r_cnt_unc;
    logic             w_out_xfer;

    assign w_out_xfer = r_out_valid && out_ready;

    // Counters follow delivered words only; clear wins over increment.
    always_ff @(posedge clk) begin
        if (rst || cnt_clear) begin
            r_cnt_corr <= '0;
            r_cnt_unc  <= '0;
        end else if (w_out_xfer) begin
            if (r_out_error && !r_out_uncorr && (r_cnt_corr != '1)) begin
                r_cnt_corr <= r_cnt_corr + 1'b1;
            end
            if (r_out_uncorr && (r_cnt_unc != '1)) begin
                r_cnt_unc <= r_cnt_unc + 1'b1;
            end
        end
    end

    assign cnt_corrected = r_cnt_corr;
    assign cnt_uncorr    = r_cnt_unc;
`else
    logic w_unused_clear;
    assign w_unused_clear = cnt_clear;
    assign cnt_corrected  = '0;
    assign cnt_uncorr     = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hamming_secded_stream_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hamming_secded_stream_decoder
//  Description : Self-checking bench for the streaming SECDED decoder (R=4).
//                A reference decoder built from the code's definition predicts
//                every delivered word; directed vectors pin exact values.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_hamming_secded_stream_decoder;

    localparam int R     = 4;
    localparam int N     = 16;
    localparam int K     = 11;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [N:1]       in_code;
    logic             out_valid;
    logic             out_ready;
    logic [K-1:0]     out_data;
    logic             out_error;
    logic             out_uncorr;
    logic [R-1:0]     out_err_index;
    logic             cnt_clear;
    logic [CNT_W-1:0] cnt_corrected;
    logic [CNT_W-1:0] cnt_uncorr;

    hamming_secded_stream_decoder #(
        .R             (R),
        .CNT_W         (CNT_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_code       (in_code),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .out_error     (out_error),
        .out_uncorr    (out_uncorr),
        .out_err_index (out_err_index),
        .cnt_clear     (cnt_clear),
        .cnt_corrected (cnt_corrected),
        .cnt_uncorr    (cnt_uncorr)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct packed {
        logic [K-1:0] data;
        logic         err;
        logic         unc;
        logic [R-1:0] idx;
    } res_t;

    function automatic bit is_pow2(input int i);
        return (i & (i - 1)) == 0;
    endfunction

    // Reference decoder: locate the error from the set-bit positions, repair
    // the codeword if it is a single error, then read out the data positions.
    function automatic res_t model(input logic [N:1] c);
        res_t       r;
        logic [N:1] f;
        int         s;
        int         p;
        int         j;
        r = '0;
        f = c;
        s = 0;
        p = 0;
        j = 0;
        for (int i = 1; i <= N; i++) begin
            if (c[i]) begin
                p = p ^ 1;
                if (i < N) s = s ^ i;
            end
        end
        r.err = (s != 0) || (p != 0);
        r.unc = (s != 0) && (p == 0);
        r.idx = s[R-1:0];
        if (s != 0 && p != 0) f[s] = ~f[s];
        for (int i = 1; i < N; i++) begin
            if (!is_pow2(i)) begin
                r.data[j] = f[i];
                j++;
            end
        end
        return r;
    endfunction

    function automatic logic [N:1] encode(input logic [K-1:0] d);
        logic [N:1] c;
        int         j;
        int         s;
        c = '0;
        j = 0;
        s = 0;
        for (int i = 1; i < N; i++) begin
            if (!is_pow2(i)) begin
                c[i] = d[j];
                j++;
            end
        end
        for (int i = 1; i < N; i++) if (c[i]) s = s ^ i;
        for (int b = 0; b < R; b++) c[1 << b] = s[b];
        c[N] = ^c;
        return c;
    endfunction

    function automatic logic [N:1] mk_word();
        logic [N:1] c;
        int         nf;
        int         p1;
        int         p2;
        c  = encode(K'($urandom));
        nf = $urandom_range(0, 2);
        p1 = $urandom_range(1, N);
        p2 = (p1 % N) + 1;
        if (nf >= 1) c[p1] = ~c[p1];
        if (nf == 2) c[p2] = ~c[p2];
        return c;
    endfunction

    // ---------------- compare process ----------------
    res_t                       q[$];
    bit                         hold_v = 1'b0;
    logic [K+R+2:0]             held;

    always @(negedge clk) begin
        res_t e;
        if (rst) begin
            q.delete();
            hold_v = 1'b0;
        end else begin
            if (hold_v) begin
                check("stall_stable", {out_valid, out_data, out_error, out_uncorr, out_err_index}, held);
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    check("unexpected_out", 32'(out_valid), 32'd0);
                end else begin
                    e = q.pop_front();
                    check("out_data",  32'(out_data),      32'(e.data));
                    check("out_error", 32'(out_error),     32'(e.err));
                    check("out_uncorr", 32'(out_uncorr),   32'(e.unc));
                    check("out_index", 32'(out_err_index), 32'(e.idx));
                end
            end
            hold_v = out_valid && !out_ready;
            held   = {out_valid, out_data, out_error, out_uncorr, out_err_index};
            if (in_valid && in_ready) q.push_back(model(in_code));
        end
    end

    // ---------------- drivers ----------------
    task automatic send(input logic [N:1] c);
        bit acc;
        acc = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_code  = c;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk); #1;
            if (acc) break;
        end
        in_valid = 1'b0;
        if (!acc) check("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic expect_out(input string name, input logic [K-1:0] d,
                              input logic e, input logic u, input logic [R-1:0] idx);
        check({name, "_valid"}, 32'(out_valid), 32'd1);
        check({name, "_data"},  32'(out_data),  32'(d));
        check({name, "_err"},   32'(out_error), 32'(e));
        check({name, "_unc"},   32'(out_uncorr), 32'(u));
        check({name, "_idx"},   32'(out_err_index), 32'(idx));
    endtask

    // Send one word with out_ready=1, check 2-cycle latency, leave at the
    // negedge where the word is presented.
    task automatic directed(input string name, input logic [N:1] c, input logic [K-1:0] d,
                            input logic e, input logic u, input logic [R-1:0] idx);
        send(c);
        @(negedge clk);
        check({name, "_lat1"}, 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        expect_out(name, d, e, u, idx);
    endtask

    task automatic drain();
        for (int t = 0; t < 100; t++) begin
            @(posedge clk); #1;
            if (q.size() == 0 && !out_valid) break;
        end
        check("drain_empty", 32'(q.size()), 32'd0);
    endtask

    task automatic stream(input int nwords, input bit rand_ready);
        int         sent;
        bit         acc;
        logic [N:1] c;
        sent = 0;
        c    = mk_word();
        for (int cyc = 0; cyc < 4000 && sent < nwords; cyc++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_code   = c;
            out_ready = rand_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
            @(negedge clk);
            acc = in_valid && in_ready;
            @(posedge clk); #1;
            if (acc) begin
                sent++;
                c = mk_word();
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("stream_sent", 32'(sent), 32'(nwords));
    endtask

    logic [N:1] codes [4];

    initial begin
        res_t m;
        int   idx;
        int   bubbles;
        bit   r;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_code   = '0;
        out_ready = 1'b1;
        cnt_clear = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_data",  32'(out_data),  32'd0);
        check("rst_err",   32'(out_error), 32'd0);
        check("rst_unc",   32'(out_uncorr), 32'd0);
        check("rst_idx",   32'(out_err_index), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_cnt_corr", 32'(cnt_corrected), 32'd0);
        check("rst_cnt_unc",  32'(cnt_uncorr), 32'd0);

        // Pin the reference decoder with hand-derived values
        m = model(16'hFFEB);
        check("model_dbl_data", 32'(m.data), 32'h7FC);
        check("model_dbl_idx",  32'(m.idx),  32'd6);
        m = model(16'hFFEF);
        check("model_sgl", 32'({m.data, m.err, m.unc, m.idx}), 32'({11'h7FF, 1'b1, 1'b0, 4'd5}));
        m = model(16'h7FFF);
        check("model_bitn", 32'({m.data, m.err, m.unc, m.idx}), 32'({11'h7FF, 1'b1, 1'b0, 4'd0}));
        check("model_enc", 32'(encode(11'h7FF)), 32'hFFFF);

        // Directed vectors: clean, single, double, overall-parity bit
        directed("clean",  16'hFFFF, 11'h7FF, 1'b0, 1'b0, 4'd0);
        directed("single", 16'hFFEF, 11'h7FF, 1'b1, 1'b0, 4'd5);
        directed("double", 16'hFFEB, 11'h7FC, 1'b1, 1'b1, 4'd6);
        directed("bitn",   16'h7FFF, 11'h7FF, 1'b1, 1'b0, 4'd0);
        drain();

`ifdef HAMMING_DEC_STATS_EN
        check("cnt_corr_2", 32'(cnt_corrected), 32'd2);
        check("cnt_unc_1",  32'(cnt_uncorr), 32'd1);
        @(posedge clk); #1 cnt_clear = 1'b1;
        @(posedge clk); #1 cnt_clear = 1'b0;
        check("cnt_corr_clr", 32'(cnt_corrected), 32'd0);
        check("cnt_unc_clr",  32'(cnt_uncorr), 32'd0);
`else
        check("cnt_corr_tied", 32'(cnt_corrected), 32'd0);
        check("cnt_unc_tied",  32'(cnt_uncorr), 32'd0);
`endif

        // Four back-to-back words against a 3-cycle output stall
        codes[0] = 16'hFFEF;
        codes[1] = 16'hFFEB;
        codes[2] = 16'h7FFF;
        codes[3] = encode(11'h2A5);
        idx = 0;
        @(posedge clk); #1;
        out_ready = 1'b0;
        for (int c = 0; c < 40 && idx < 4; c++) begin
            in_valid = 1'b1;
            in_code  = codes[idx];
            if (c == 5) out_ready = 1'b1;
            @(negedge clk);
            r = in_ready;
            if (c == 2) begin
                check("stall_in_ready", 32'(in_ready), 32'd0);
                check("stall_accepted", 32'(idx), 32'd2);
            end
            @(posedge clk); #1;
            if (r) idx++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("stall_all_sent", 32'(idx), 32'd4);
        drain();

        // Sustained throughput: no bubbles with out_ready held high
        bubbles = 0;
        for (int c = 0; c < 8; c++) begin
            in_valid = 1'b1;
            in_code  = mk_word();
            @(negedge clk);
            if (!in_ready) bubbles++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check("no_bubbles", 32'(bubbles), 32'd0);
        drain();

        // Random traffic with random backpressure
        stream(120, 1'b1);
        drain();

        // Reset while the pipeline is full and stalled
        out_ready = 1'b0;
        send(16'hFFFF);
        send(16'hFFEF);
        @(negedge clk);
        check("pre_rst_full", 32'({out_valid, in_ready}), 32'b10);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("midrst_valid", 32'(out_valid), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        bubbles = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (out_valid) bubbles++;
        end
        check("midrst_dropped", 32'(bubbles), 32'd0);

        check("final_queue", 32'(q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
